// File: rtl/mux_nto1_stream.sv
// N-channel stream multiplexer with per-channel valid/ready and packet locking.
// Arbitration is round-robin or external select. The selected beat is registered into one output slot.
module mux_nto1_stream #(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready,
    output logic                     busy
);

    // Handshake: a beat moves on a rising edge only when valid and ready are both
    // high on the same channel. A producer must not make valid depend on ready.
    // in_ready is combinational from the state, the output slot and arbitration.

    localparam int PAD_W = 1 << SEL_W;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_grant;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_out_last;
    logic [SEL_W-1:0]   r_out_ch;

    logic               w_slot_free;
    logic               w_rr_found;
    logic [SEL_W-1:0]   w_rr_win;
    logic [PAD_W-1:0]   w_valid_pad;
    logic               w_fix_ok;
    logic [SEL_W-1:0]   w_cand;
    logic               w_cand_ok;
    logic [DATA_W-1:0]  w_cand_data;
    logic               w_cand_last;
    logic [NUM_CH-1:0]  w_ready;
    logic               w_xfer;

    assign w_slot_free = !r_out_valid || out_ready;

    // The scan runs from the farthest offset down, so the nearest valid channel after rr_ptr wins.
    always_comb begin
        logic [SEL_W-1:0] w_idx;
        w_rr_found = 1'b0;
        w_rr_win   = '0;
        w_idx      = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_idx = SEL_W'((int'(r_rr_ptr) + i) % NUM_CH);
            if (in_valid[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_win   = w_idx;
            end
        end
    end

    // Padding makes an out-of-range sel read a zero valid bit, so it can never grant.
    assign w_valid_pad = PAD_W'(in_valid);
    assign w_fix_ok    = w_valid_pad[sel];

    always_comb begin
        w_cand    = '0;
        w_cand_ok = 1'b0;
        if (r_state == S_LOCKED) begin
            w_cand    = r_grant;
            w_cand_ok = 1'b1;
        end else if (mode) begin
            w_cand    = sel;
            w_cand_ok = w_fix_ok;
        end else begin
            w_cand    = w_rr_win;
            w_cand_ok = w_rr_found;
        end
    end

    always_comb begin
        w_cand_data = '0;
        w_cand_last = 1'b0;
        w_ready     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (SEL_W'(k) == w_cand) begin
                w_cand_data = in_data[k*DATA_W +: DATA_W];
                w_cand_last = in_last[k];
                w_ready[k]  = rst_n && w_slot_free && w_cand_ok;
            end
        end
    end

    assign in_ready = w_ready;
    assign w_xfer   = |(in_valid & w_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= SEL_W'(NUM_CH - 1);
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_cand_data;
                r_out_last  <= w_cand_last;
                r_out_ch    <= w_cand;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (w_cand_last) begin
                            r_rr_ptr <= w_cand;
                        end else begin
                            r_grant <= w_cand;
                            r_state <= S_LOCKED;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_xfer && w_cand_last) begin
                        r_rr_ptr <= r_grant;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;
    assign busy      = (r_state == S_LOCKED);

endmodule
